alu_muldiv_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the MIPS datapath. It extends the single-cycle ALU op set with shifts and iterative MULT/MULTU/DIV/DIVU writing HI/LO.

---
 rtl/alu_muldiv_seq_if.sv | 28 ++
 rtl/alu_muldiv_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Handshake/operand bundle for alu_muldiv_seq: the control unit drives the master side.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [31:0]      NFlag;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUOp, x, y, shamt,
    input  result, hi, lo, NFlag, busy, done
  );

  modport slave (
    input  start, ALUOp, x, y, shamt,
    output result, hi, lo, NFlag, busy, done
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MIPS ALU: single-cycle ops plus iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Optional ALU_DIVZERO_FLAG_EN: NFlag bit2 reports divide-by-zero on DIV/DIVU completion.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_muldiv_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ONE  = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]         state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   x_q, y_q, dv;
  logic [SHW-1:0]     shamt_q, cnt;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q, xneg_q, dz_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    mag = (s && v[WIDTH-1]) ? -v : v;
  endfunction

  logic start_sgn;
  assign start_sgn = ~bus.ALUOp[0];

  // Single-cycle datapath on latched operands
  logic [WIDTH-1:0] sum, dif, alu_res;
  logic             alu_ovf;
  assign sum = x_q + y_q;
  assign dif = x_q - y_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      4'h0: begin
        alu_res = sum;
        alu_ovf = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
      end
      4'h1: begin
        alu_res = dif;
        alu_ovf = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (dif[WIDTH-1] != x_q[WIDTH-1]);
      end
      4'h2: alu_res = x_q & y_q;
      4'h3: alu_res = x_q | y_q;
      4'h4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
      4'h5: alu_res = y_q;
      4'h6: alu_res = y_q << shamt_q;
      4'h7: alu_res = y_q >> shamt_q;
      default: alu_res = '0;
    endcase
  end

  // acc = {partial product, multiplier} for MUL, {remainder, quotient} for DIV
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  logic                 div_ok;
  logic [WIDTH-1:0]     rem_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? dv : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  // The shifted remainder minus divisor always fits WIDTH bits when the trial succeeds
  assign div_ok   = (acc[2*WIDTH-1:WIDTH-1] >= {1'b0, dv});
  assign rem_next = div_ok ? (acc[2*WIDTH-2:WIDTH-1] - dv) : acc[2*WIDTH-2:WIDTH-1];
  assign div_next = {rem_next, acc[WIDTH-2:0], div_ok};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  logic               dz_flag;
  assign prod   = neg_q ? -acc : acc;
  assign fin_lo = op_q[1] ? (dz_q ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]))
                          : prod[WIDTH-1:0];
  assign fin_hi = op_q[1] ? (xneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                          : prod[2*WIDTH-1:WIDTH];

`ifdef ALU_DIVZERO_FLAG_EN
  assign dz_flag = dz_q;
`else
  assign dz_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      shamt_q    <= '0;
      cnt        <= '0;
      acc        <= '0;
      dv         <= '0;
      neg_q      <= 1'b0;
      xneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      bus.result <= '0;
      bus.hi     <= '0;
      bus.lo     <= '0;
      bus.NFlag  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.ALUOp;
            x_q     <= bus.x;
            y_q     <= bus.y;
            shamt_q <= bus.shamt;
            cnt     <= '0;
            case (bus.ALUOp)
              4'h8, 4'h9: begin
                acc      <= {{WIDTH{1'b0}}, mag(bus.y, start_sgn)};
                dv       <= mag(bus.x, start_sgn);
                neg_q    <= start_sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
                xneg_q   <= 1'b0;
                dz_q     <= 1'b0;
                bus.busy <= 1'b1;
                state    <= S_MUL;
              end
              4'hA, 4'hB: begin
                acc      <= {{WIDTH{1'b0}}, mag(bus.x, start_sgn)};
                dv       <= mag(bus.y, start_sgn);
                neg_q    <= start_sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
                xneg_q   <= start_sgn & bus.x[WIDTH-1];
                dz_q     <= (bus.y == '0);
                bus.busy <= 1'b1;
                state    <= S_DIV;
              end
              default: state <= S_ONE;
            endcase
          end
        end
        S_ONE: begin
          bus.result <= alu_res;
          bus.NFlag  <= {30'b0, (alu_res == '0), alu_ovf};
          bus.done   <= 1'b1;
          state      <= S_IDLE;
        end
        S_MUL, S_DIV: begin
          acc <= (state == S_MUL) ? mul_next : div_next;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) state <= S_FIN;
        end
        S_FIN: begin
          bus.hi     <= fin_hi;
          bus.lo     <= fin_lo;
          bus.result <= fin_lo;
          bus.NFlag  <= {29'b0, dz_flag, (fin_lo == '0), 1'b0};
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq (WIDTH=32), hand-computed expectations.
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_dz;

  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
    bus.start = 1'b1;
    bus.ALUOp = op;
    bus.x     = a;
    bus.y     = b;
    bus.shamt = sh;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ALUOp = 4'h0;
    bus.x     = $urandom;
    bus.y     = $urandom;
    bus.shamt = 5'($urandom);
  endtask

  task automatic run_one(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic [31:0] exp_nf);
    launch(op, a, b, sh);
    chk({tag, "_done_e0"}, {31'b0, bus.done}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_nflag"}, bus.NFlag, exp_nf);
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
  endtask

  task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic [31:0] exp_nf);
    int bad;
    bad = 0;
    launch(op, a, b, 5'd0);
    chk({tag, "_busy_e0"}, {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    chk({tag, "_busy_window"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    chk({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    chk({tag, "_result"}, bus.result, exp_lo);
    chk({tag, "_nflag"}, bus.NFlag, exp_nf);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
`ifdef ALU_DIVZERO_FLAG_EN
    exp_dz = 32'h4;
`else
    exp_dz = 32'h0;
`endif
    bus.start = 1'b0;
    bus.ALUOp = 4'h0;
    bus.x     = '0;
    bus.y     = '0;
    bus.shamt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_nflag", bus.NFlag, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_one("add_ovf", 4'h0, 32'h7fffffff, 32'h00000001, 5'd0, 32'h80000000, 32'h1);
    run_one("add_wrap0", 4'h0, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000000, 32'h2);
    run_one("sub_zero", 4'h1, 32'h0000012c, 32'h0000012c, 5'd0, 32'h00000000, 32'h2);
    run_one("sub_ovf", 4'h1, 32'h80000000, 32'h00000001, 5'd0, 32'h7fffffff, 32'h1);
    run_one("and", 4'h2, 32'hff00ff00, 32'h0ff00ff0, 5'd0, 32'h0f000f00, 32'h0);
    run_one("or", 4'h3, 32'hff00ff00, 32'h0ff00ff0, 5'd0, 32'hfff0fff0, 32'h0);
    run_one("less", 4'h4, 32'h00000100, 32'h00000200, 5'd0, 32'h00000001, 32'h0);
    run_one("less_neg", 4'h4, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000001, 32'h0);
    run_one("less_no", 4'h4, 32'h00000001, 32'hffffffff, 5'd0, 32'h00000000, 32'h2);
    run_one("pass_b", 4'h5, 32'h12345678, 32'hdeadbeef, 5'd0, 32'hdeadbeef, 32'h0);
    run_one("sll31", 4'h6, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 32'h0);
    run_one("srl4", 4'h7, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 32'h0);
    run_one("op_c", 4'hC, 32'hffffffff, 32'hffffffff, 5'd3, 32'h00000000, 32'h2);
    run_one("op_f", 4'hF, 32'h00000001, 32'h00000002, 5'd1, 32'h00000000, 32'h2);

    run_long("mult", 4'h8, 32'hfffffffd, 32'h00000007, 32'hffffffff, 32'hffffffeb, 32'h0);
    run_long("multu", 4'h9, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 32'h0);
    run_long("divu", 4'hB, 32'd100, 32'd7, 32'h00000002, 32'h0000000e, 32'h0);
    run_long("div_neg", 4'hA, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 32'h0);
    run_long("div_min", 4'hA, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 32'h0);
    run_long("div_z", 4'hA, 32'h00000005, 32'h00000000, 32'h00000005, 32'hffffffff, exp_dz);
    run_long("div_zneg", 4'hA, 32'hfffffffb, 32'h00000000, 32'hfffffffb, 32'hffffffff, exp_dz);
    run_long("divu_z", 4'hB, 32'h00000005, 32'h00000000, 32'h00000005, 32'hffffffff, exp_dz);

    // MULTU in flight: a start at E5 must be ignored, then reset at E10 aborts it
    launch(4'h9, 32'd3, 32'd3, 5'd0);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.ALUOp = 4'h0;
    bus.x     = 32'd1;
    bus.y     = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("ign_done", {31'b0, bus.done}, 32'd0);
    chk("ign_busy", {31'b0, bus.busy}, 32'd1);
    chk("ign_result", bus.result, 32'hffffffff);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'h0);
    chk("arst_lo", bus.lo, 32'h0);
    chk("arst_result", bus.result, 32'h0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_one("sub_after_rst", 4'h1, 32'd5, 32'd3, 5'd0, 32'h00000002, 32'h0);
    chk("after_rst_hi", bus.hi, 32'h0);
    chk("after_rst_lo", bus.lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
